psum_ctrl: RTL

Sequencer for the ping-pong partial-sum buffer of the conv kernel. It generates p_init, p_valid_data, p_write_zero and odd_cnt so that one output row accumulates over cfg_num_pass passes while the previous row's finished sums drain. It sits between the conv layer controller (start/done/config) and the PE array valid stream, and it back-pressures the PE array via pe_ready.

---
 rtl/psum_ctrl.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/psum_ctrl.sv
// ---------------------------------------------------------------------------
// psum_ctrl
//   Sequencer for the conv kernel's ping-pong partial-sum buffer. One output
//   row accumulates over cfg_num_pass passes in one FIFO. Meanwhile the other
//   FIFO drains the previous row's finished sums and is refilled with zero,
//   in step with the incoming beats.
//
//   Flow: IDLE -> INIT -> (RUN -> TURN)* -> FLUSH -> DONE -> IDLE
//         IDLE -> DONE (cfg_err) when the configuration is illegal.
//
// Parameters
//   DEPTH    psum FIFO depth, which is also the maximum row length
//   CNT_W    width of the beat/pass/row counters and the config fields
//   PIPE_LAT adder-tree latency from p_valid_data to the FIFO write
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   start             one-cycle pulse that begins a layer (IDLE only)
//   cfg_row_len       psum entries per output row      (sampled on start)
//   cfg_num_pass      accumulation passes per row      (sampled on start)
//   cfg_num_rows      output rows in the layer         (sampled on start)
//   pe_valid          PE array offers a beat
//   pe_ready          beat accepted this cycle (RUN only, combinational)
//   p_init            write zero into both FIFOs
//   p_valid_data      beat accepted (pe_valid & pe_ready, combinational)
//   p_write_zero      drain the idle FIFO and refill it with zero
//   odd_cnt           ping-pong select
//   busy              high in every state except IDLE
//   done              one-cycle pulse at the end of the layer
//   cfg_err           pulses together with done on an illegal config
//   perf_stall_cnt    RUN cycles without pe_valid (PSUM_CTRL_PERF_EN only)
//
// Build option
//   PSUM_CTRL_PERF_EN  when defined, enables the 16-bit saturating stall
//                      counter. Otherwise perf_stall_cnt is tied to 0.
// ---------------------------------------------------------------------------
module psum_ctrl #(
  parameter int DEPTH    = 61,
  parameter int CNT_W    = 8,
  parameter int PIPE_LAT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_row_len,
  input  logic [CNT_W-1:0] cfg_num_pass,
  input  logic [CNT_W-1:0] cfg_num_rows,
  input  logic             pe_valid,
  output logic             pe_ready,
  output logic             p_init,
  output logic             p_valid_data,
  output logic             p_write_zero,
  output logic             odd_cnt,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [15:0]      perf_stall_cnt
);

  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(PIPE_LAT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_TURN  = 3'd3,
    S_FLUSH = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q,  len_d;
  logic [CNT_W-1:0] npass_q, npass_d;
  logic [CNT_W-1:0] nrows_q, nrows_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;    // cycle counter for INIT/TURN/FLUSH
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0] row_q,  row_d;
  logic             odd_q,  odd_d;
  logic             err_q,  err_d;

  // Registered outputs, each computed from the next state.
  logic init_q,  init_d;
  logic busy_q,  busy_d;
  logic done_q,  done_d;
  logic cerr_q,  cerr_d;
  logic flush_q, flush_d;
  // Marks that the current pass drains the idle FIFO, i.e. pass 0 of any row
  // after the first. It is ANDed with the beat strobe so that the drain stays
  // beat-aligned even when pe_valid has bubbles.
  logic drain_q, drain_d;

  logic accept;
  logic cfg_bad;
  logic last_beat;
  logic last_pass;

  assign accept    = (state_q == S_RUN) && pe_valid;
  assign last_beat = (beat_q == len_q - ONE);
  assign last_pass = (pass_q == npass_q - ONE);
  assign cfg_bad   = (cfg_row_len == '0) || (cfg_num_pass == '0) ||
                     (cfg_num_rows == '0) || (cfg_row_len > DEPTH_C);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    npass_d = npass_q;
    nrows_d = nrows_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    pass_d  = pass_q;
    row_d   = row_q;
    odd_d   = odd_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d   = cfg_row_len;
          npass_d = cfg_num_pass;
          nrows_d = cfg_num_rows;
          cnt_d   = '0;
          beat_d  = '0;
          pass_d  = '0;
          row_d   = '0;
          err_d   = cfg_bad;
          if (cfg_bad) begin
            state_d = S_DONE;
          end else begin
            odd_d   = 1'b0;
            state_d = S_INIT;
          end
        end
      end

      S_INIT: begin
        if (cnt_q == len_q - ONE) begin
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      S_RUN: begin
        if (accept) begin
          if (last_beat) begin
            beat_d = '0;
            if (last_pass) begin
              pass_d  = '0;
              cnt_d   = '0;
              state_d = S_TURN;
            end else begin
              pass_d = pass_q + ONE;
            end
          end else begin
            beat_d = beat_q + ONE;
          end
        end
      end

      // PIPE_LAT+1 dead cycles: the adder tree retires its last row, and the
      // buffer gets one extra cycle to see the new odd_cnt.
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          odd_d   = ~odd_q;
          row_d   = row_q + ONE;
          state_d = (row_q == nrows_q - ONE) ? S_FLUSH : S_RUN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      S_FLUSH: begin
        if (cnt_q == len_q - ONE) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end

      S_DONE: begin
        err_d   = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    init_d  = (state_d == S_INIT);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    cerr_d  = (state_d == S_DONE) && err_d;
    flush_d = (state_d == S_FLUSH);
    drain_d = (state_d == S_RUN) && (pass_d == '0) && (row_d != '0);
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      npass_q <= '0;
      nrows_q <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      pass_q  <= '0;
      row_q   <= '0;
      odd_q   <= 1'b0;
      err_q   <= 1'b0;
      init_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
      flush_q <= 1'b0;
      drain_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      npass_q <= npass_d;
      nrows_q <= nrows_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      pass_q  <= pass_d;
      row_q   <= row_d;
      odd_q   <= odd_d;
      err_q   <= err_d;
      init_q  <= init_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
      flush_q <= flush_d;
      drain_q <= drain_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign pe_ready     = (state_q == S_RUN);
  assign p_valid_data = pe_ready && pe_valid;
  assign p_write_zero = flush_q || (p_valid_data && drain_q);
  assign p_init       = init_q;
  assign odd_cnt      = odd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cerr_q;

`ifdef PSUM_CTRL_PERF_EN
  // Stall counter: RUN cycles with no beat offered. It clears on an
  // accepted start and holds its value across done until the next layer.
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && !pe_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = 16'd0;
`endif

endmodule
